// File: rtl/rvm_wb_stage_if.sv
// rvm_wb_stage_if: result and register-file handshake bundle around the writeback stage.
//   fu_valid/fu_result/fu_rd/fu_ready : functional-unit result handshake
//   rf_wen/rf_waddr/rf_wdata/rf_ready : register-file write-port handshake
// slave  = the writeback stage's view; master = the surrounding core's view.
interface rvm_wb_stage_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              fu_valid;
    logic [DATA_W-1:0] fu_result;
    logic [ADDR_W-1:0] fu_rd;
    logic              fu_ready;

    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_ready;

    modport slave (
        input  fu_valid, fu_result, fu_rd, rf_ready,
        output fu_ready, rf_wen, rf_waddr, rf_wdata
    );

    modport master (
        output fu_valid, fu_result, fu_rd, rf_ready,
        input  fu_ready, rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rvm_wb_stage.sv
// rvm_wb_stage: writeback stage. Buffers up to two completed functional-unit
// results in a 2-entry in-order FIFO and drains them into the register file.
// Writes to x0 are dropped without a register-file request; every pop is
// counted in retire_count.
// Ports:
//   clk, resetn       : clock, asynchronous active-low reset
//   wb (slave)        : fu_* result handshake in, rf_* write port out
//   flush             : synchronous discard of all buffered entries
//   retire_count      : number of results retired since reset (wraps)
//   byp_rs1/2, byp_hit1/2, byp_data1/2 : buffer lookup, present only when
//                       RVM_WB_BYPASS_EN is defined
// Optional feature macro: RVM_WB_BYPASS_EN
module rvm_wb_stage #(
    parameter int unsigned DEPTH = 2   // only 2 is supported
) (
    input  logic                clk,
    input  logic                resetn,
    rvm_wb_stage_if.slave       wb,
    input  logic                flush,
    output logic [31:0]         retire_count
`ifdef RVM_WB_BYPASS_EN
    ,
    input  logic [4:0]          byp_rs1,
    input  logic [4:0]          byp_rs2,
    output logic                byp_hit1,
    output logic                byp_hit2,
    output logic [31:0]         byp_data1,
    output logic [31:0]         byp_data2
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned RET_W  = 32;

    // FIFO storage and pointers
    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [ADDR_W-1:0] rd_q    [DEPTH];
    logic [ADDR_W-1:0] rd_d    [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [RET_W-1:0]  retire_cnt_q, retire_cnt_d;

    logic              head_valid_c;
    logic [ADDR_W-1:0] head_rd_c;
    logic [DATA_W-1:0] head_data_c;
    logic              fu_ready_c;
    logic              rf_wen_c;
    logic              push_c;
    logic              pop_c;

    // Head decode; every rf_* output depends on registered state only
    assign head_valid_c = valid_q[head_q];
    assign head_rd_c    = rd_q[head_q];
    assign head_data_c  = data_q[head_q];

    assign fu_ready_c = (count_q != CNT_W'(2));
    assign rf_wen_c   = head_valid_c && (head_rd_c != '0);
    // x0 entries leave without waiting for the register file
    assign pop_c      = head_valid_c && ((head_rd_c == '0) || wb.rf_ready);
    assign push_c     = wb.fu_valid && fu_ready_c;

    assign wb.fu_ready = fu_ready_c;
    assign wb.rf_wen   = rf_wen_c;
    assign wb.rf_waddr = head_valid_c ? head_rd_c   : '0;
    assign wb.rf_wdata = head_valid_c ? head_data_c : '0;
    assign retire_count = retire_cnt_q;

    // Next-state: push at tail, pop at head, flush overrides both
    always_comb begin
        valid_d      = valid_q;
        rd_d         = rd_q;
        data_d       = data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        retire_cnt_d = retire_cnt_q;

        if (flush) begin
            valid_d = '{default: 1'b0};
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = '0;
            // a write the register file took this cycle still retired
            if (rf_wen_c && wb.rf_ready) begin
                retire_cnt_d = retire_cnt_q + RET_W'(1);
            end
        end else begin
            if (pop_c) begin
                valid_d[head_q] = 1'b0;
                head_d          = ~head_q;
                retire_cnt_d    = retire_cnt_q + RET_W'(1);
            end
            if (push_c) begin
                valid_d[tail_q] = 1'b1;
                rd_d[tail_q]    = wb.fu_rd;
                data_d[tail_q]  = wb.fu_result;
                tail_d          = ~tail_q;
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q      <= '{default: 1'b0};
            rd_q         <= '{default: '0};
            data_q       <= '{default: '0};
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            count_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

`ifdef RVM_WB_BYPASS_EN
    // Newest-first search: tail-1 then head; {hit, data}, zero on miss
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] rs);
        logic newest;
        newest = ~tail_q;
        lookup = '0;
        if (rs != '0) begin
            if (valid_q[newest] && (rd_q[newest] == rs)) begin
                lookup = {1'b1, data_q[newest]};
            end else if (valid_q[head_q] && (rd_q[head_q] == rs)) begin
                lookup = {1'b1, data_q[head_q]};
            end
        end
    endfunction

    always_comb begin
        {byp_hit1, byp_data1} = lookup(byp_rs1);
        {byp_hit2, byp_data2} = lookup(byp_rs2);
    end
`endif

endmodule

// File: tb/tb_rvm_wb_stage.sv
// tb_rvm_wb_stage: directed self-checking bench for rvm_wb_stage.
module tb_rvm_wb_stage;

    logic clk;
    logic resetn;
    logic flush;
    logic [31:0] retire_count;

    int n_assert;
    int n_fail;

    rvm_wb_stage_if wb ();

`ifdef RVM_WB_BYPASS_EN
    logic [4:0]  byp_rs1, byp_rs2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    rvm_wb_stage #(.DEPTH(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wb           (wb.slave),
        .flush        (flush),
        .retire_count (retire_count)
`ifdef RVM_WB_BYPASS_EN
        ,
        .byp_rs1      (byp_rs1),
        .byp_rs2      (byp_rs2),
        .byp_hit1     (byp_hit1),
        .byp_hit2     (byp_hit2),
        .byp_data1    (byp_data1),
        .byp_data2    (byp_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wb.fu_valid  = 1'b1;
        wb.fu_rd     = rd;
        wb.fu_result = data;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        resetn       = 1'b0;
        flush        = 1'b0;
        wb.fu_valid  = 1'b0;
        wb.fu_rd     = '0;
        wb.fu_result = '0;
        wb.rf_ready  = 1'b0;
`ifdef RVM_WB_BYPASS_EN
        byp_rs1 = '0;
        byp_rs2 = '0;
`endif
        #2;
        // reset values
        check("rst_fu_ready", 32'(wb.fu_ready), 32'd1);
        check("rst_rf_wen",   32'(wb.rf_wen),   32'd0);
        check("rst_rf_waddr", 32'(wb.rf_waddr), 32'd0);
        check("rst_rf_wdata", wb.rf_wdata,      32'd0);
        check("rst_retire",   retire_count,     32'd0);
        step();
        step();
        resetn = 1'b1;

        // single result, register file ready
        wb.rf_ready = 1'b1;
        push(5'd5, 32'hDEAD_BEEF);
        check("t1_no_comb_path", 32'(wb.rf_wen), 32'd0);
        step();
        wb.fu_valid = 1'b0;
        check("t1_wen",    32'(wb.rf_wen),   32'd1);
        check("t1_waddr",  32'(wb.rf_waddr), 32'd5);
        check("t1_wdata",  wb.rf_wdata,      32'hDEAD_BEEF);
        check("t1_ret0",   retire_count,     32'd0);
        step();
        check("t1_ret1",   retire_count,     32'd1);
        check("t1_idle",   32'(wb.rf_wen),   32'd0);
        check("t1_idle_a", 32'(wb.rf_waddr), 32'd0);

        // backpressure: two accepts fill the buffer, the third waits
        wb.rf_ready = 1'b0;
        push(5'd1, 32'h11);
        step();
        check("t2_rdy_c1", 32'(wb.fu_ready), 32'd1);
        check("t2_addr1",  32'(wb.rf_waddr), 32'd1);
        push(5'd2, 32'h22);
        step();
        check("t2_full",   32'(wb.fu_ready), 32'd0);
        push(5'd3, 32'h33);
        step();
        check("t2_still_full", 32'(wb.fu_ready), 32'd0);
        check("t2_hold_wen",   32'(wb.rf_wen),   32'd1);
        check("t2_hold_addr",  32'(wb.rf_waddr), 32'd1);
        check("t2_hold_data",  wb.rf_wdata,      32'h11);
        wb.rf_ready = 1'b1;
        step();
        check("t2_addr2",  32'(wb.rf_waddr), 32'd2);
        check("t2_data2",  wb.rf_wdata,      32'h22);
        check("t2_ret2",   retire_count,     32'd2);
        check("t2_rdy_ag", 32'(wb.fu_ready), 32'd1);
        step();
        wb.fu_valid = 1'b0;
        check("t2_addr3",  32'(wb.rf_waddr), 32'd3);
        check("t2_data3",  wb.rf_wdata,      32'h33);
        check("t2_ret3",   retire_count,     32'd3);
        step();
        check("t2_ret4",   retire_count,     32'd4);
        check("t2_empty",  32'(wb.rf_wen),   32'd0);

        // x0 destination: discarded without a write, still retired
        wb.rf_ready = 1'b0;
        push(5'd0, 32'h1234);
        step();
        wb.fu_valid = 1'b0;
        check("t3_no_wen", 32'(wb.rf_wen),   32'd0);
        check("t3_ret4",   retire_count,     32'd4);
        step();
        check("t3_ret5",   retire_count,     32'd5);
        check("t3_count",  32'(dut.count_q), 32'd0);
        check("t3_no_wen2", 32'(wb.rf_wen),  32'd0);

        // flush on a full buffer with a push in the same cycle
        push(5'd9, 32'h99);
        step();
        push(5'd10, 32'hAA);
        step();
        check("t4_full",   32'(wb.fu_ready), 32'd0);
        flush = 1'b1;
        push(5'd11, 32'hBB);
        step();
        flush = 1'b0;
        wb.fu_valid = 1'b0;
        check("t4_count",  32'(dut.count_q), 32'd0);
        check("t4_ready",  32'(wb.fu_ready), 32'd1);
        check("t4_wen",    32'(wb.rf_wen),   32'd0);
        wb.rf_ready = 1'b1;
        step();
        step();
        check("t4_no_write", 32'(wb.rf_wen), 32'd0);
        check("t4_ret",    retire_count,     32'd5);

        // flush while the register file takes the head write
        wb.rf_ready = 1'b0;
        push(5'd12, 32'hCC);
        step();
        wb.fu_valid = 1'b0;
        flush       = 1'b1;
        wb.rf_ready = 1'b1;
        step();
        flush = 1'b0;
        check("t4b_ret",   retire_count,     32'd6);
        check("t4b_wen",   32'(wb.rf_wen),   32'd0);

        // retire counter wrap
        dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        check("t5_preload", retire_count, 32'hFFFF_FFFF);
        push(5'd4, 32'h44);
        step();
        wb.fu_valid = 1'b0;
        step();
        check("t5_wrap",   retire_count,     32'd0);

        // sustained throughput with rf_ready held high
        push(5'd20, 32'h200);
        step();
        check("t6_a20",    32'(wb.rf_waddr), 32'd20);
        push(5'd21, 32'h210);
        step();
        check("t6_a21",    32'(wb.rf_waddr), 32'd21);
        check("t6_rdy",    32'(wb.fu_ready), 32'd1);
        check("t6_ret1",   retire_count,     32'd1);
        push(5'd22, 32'h220);
        step();
        wb.fu_valid = 1'b0;
        check("t6_a22",    32'(wb.rf_waddr), 32'd22);
        check("t6_d22",    wb.rf_wdata,      32'h220);
        step();
        check("t6_ret3",   retire_count,     32'd3);
        check("t6_idle",   32'(wb.rf_wen),   32'd0);

`ifdef RVM_WB_BYPASS_EN
        // bypass lookup: newest matching entry wins, x0 never hits
        wb.rf_ready = 1'b0;
        push(5'd7, 32'hA);
        step();
        push(5'd7, 32'hB);
        step();
        wb.fu_valid = 1'b0;
        byp_rs1 = 5'd7;
        byp_rs2 = 5'd0;
        #1;
        check("byp_hit1",  32'(byp_hit1),    32'd1);
        check("byp_data1", byp_data1,        32'hB);
        check("byp_hit2",  32'(byp_hit2),    32'd0);
        check("byp_data2", byp_data2,        32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("byp_miss",  32'(byp_hit1),    32'd0);
`endif

        // asynchronous reset in the middle of a pending write
        wb.rf_ready = 1'b0;
        push(5'd6, 32'h66);
        step();
        wb.fu_valid = 1'b0;
        check("t7_pending", 32'(wb.rf_wen),  32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("t7_wen_drop", 32'(wb.rf_wen), 32'd0);
        check("t7_ret",    retire_count,     32'd0);
        check("t7_ready",  32'(wb.fu_ready), 32'd1);
        step();
        resetn = 1'b1;
        step();
        check("t7_after",  32'(wb.rf_wen),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rvm_wb_stage.md
# rvm_wb_stage

Writeback stage of the RISCV multi-cycle core. Sits directly downstream of the functional units (`rvm_bitwise` and its siblings) and consumes their `valid`/`result` output together with the destination register index. It buffers up to two completed results and drains them, in order, into the register file write port under a ready handshake. Writes to x0 are discarded, and every retired result is counted.

## Interface
Parameters:
- `DEPTH`, 2: buffer entries. Only 2 is supported.

Ports:
- `clk` in 1: core clock. All state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `fu_valid` in 1: functional unit result is complete. Driven from the unit's `valid`.
- `fu_result` in 32: result value. Driven from the unit's `result`.
- `fu_rd` in 5: destination register index.
- `fu_ready` out 1: stage can accept a result this cycle.
- `flush` in 1: synchronous discard of all buffered entries.
- `rf_wen` out 1: register file write request.
- `rf_waddr` out 5: write address.
- `rf_wdata` out 32: write data.
- `rf_ready` in 1: register file accepts the write this cycle.
- `retire_count` out 32: number of results retired since reset.
- With `RVM_WB_BYPASS_EN` only:
  - `byp_rs1` in 5, `byp_rs2` in 5: register indices to look up.
  - `byp_hit1` out 1, `byp_hit2` out 1: a lookup matched a buffered entry.
  - `byp_data1` out 32, `byp_data2` out 32: data of the matched entry.

## Operation
- Storage is a 2-entry in-order FIFO.
  - Each entry holds {valid, rd[4:0], data[31:0]}.
  - A 1-bit head pointer and a 1-bit tail pointer wrap modulo 2.
  - A 2-bit `count` runs 0..2.
- Push: when `fu_valid && fu_ready`, the tuple {`fu_rd`, `fu_result`} is written at the tail.
- Ready: `fu_ready = (count != 2)`. It is a function of registered state only and never of `rf_ready`.
- Drain, when head is valid and head.rd != 0:
  - `rf_wen = 1`, `rf_waddr = head.rd`, `rf_wdata = head.data`.
  - The entry pops when `rf_ready = 1`.
- Drain, when head is valid and head.rd == 0:
  - `rf_wen` stays 0.
  - The entry pops unconditionally in that cycle, ignoring `rf_ready`.
- Idle: when the buffer is empty, `rf_wen = 0`, and `rf_waddr`/`rf_wdata` are 0.
- Retire count: `retire_count` increments by 1 on every pop, including x0 discards. It wraps from 0xFFFFFFFF to 0.
- Simultaneous push and pop:
  - `count` is unchanged.
  - Both pointers advance.
  - This is legal at count 1. At count 0, the pushed entry cannot be popped in the same cycle.
- Flush:
  - Clears all entry valid bits, `count`, and both pointers.
  - A push in the same cycle is dropped.
  - A pop in the same cycle still counts toward `retire_count` if `rf_wen && rf_ready` held.
- Reset mid-drain: the pending write is lost and `rf_wen` falls asynchronously.

## Timing
- Reset values (all outputs):
  - `fu_ready = 1`.
  - `rf_wen = 0`, `rf_waddr = 0`, `rf_wdata = 0`.
  - `retire_count = 0`.
  - `byp_hit1/2 = 0`, `byp_data1/2 = 0`.
- Latency: a result accepted on edge N drives `rf_wen` during cycle N+1 at the earliest. There is no combinational `fu_*` to `rf_*` path.
- Throughput: one result per cycle sustained while `rf_ready` stays high.
- Backpressure:
  - When `rf_ready` is low, the buffer fills after 2 pushes.
  - `fu_ready` drops in the cycle after the second accept.
- `rf_wen`, `rf_waddr` and `rf_wdata` are stable while `rf_wen && !rf_ready`.

## Configuration
- `RVM_WB_BYPASS_EN` defined:
  - The bypass ports exist.
  - For each lookup, the valid buffered entries are searched newest-first (tail-1, then head) for rd == `byp_rsN` with rd != 0.
  - `byp_hitN` and `byp_dataN` are combinational from state and the `byp_rsN` inputs.
  - On a miss, `byp_hitN = 0` and `byp_dataN = 0`.
- `RVM_WB_BYPASS_EN` undefined:
  - The bypass ports and lookup logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then push {rd=5, 0xDEADBEEF} with `rf_ready=1` -> `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF` one cycle later; `retire_count=1` after the next edge.
- Hold `rf_ready=0` and push rd=1, rd=2, rd=3 back-to-back -> rd=3 is not accepted (`fu_ready=0` after 2 accepts); raising `rf_ready` drains 1 then 2 in order, then accepts 3.
- Push {rd=0, 0x1234} with `rf_ready=0` -> `rf_wen` never asserts; the entry pops in 1 cycle; `retire_count` increments by 1.
- Buffer full, assert `flush` together with `fu_valid` -> `count=0`, `fu_ready=1`, `rf_wen=0` next cycle; the flushed results are never written.
- Preload `retire_count` to 0xFFFFFFFF through the bench hierarchy, then retire one result -> `retire_count=0`.
- `RVM_WB_BYPASS_EN`, `rf_ready=0`, buffer holds {rd=7, 0xA} (older) and {rd=7, 0xB} (newer); query `byp_rs1=7`, `byp_rs2=0` -> `byp_hit1=1`, `byp_data1=0xB`, `byp_hit2=0`.
